// File: rtl/mac_pkg.sv
// +----------------------------------------------------------------------+
// | mac_pkg : shared types and constants for the mac_engine dot product |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } mac_state_t;

  localparam int PIX_W   = 8;
  localparam int WGT_W   = 8;
  localparam int ACC_W   = 32;
  localparam int RES_W   = 17;
  localparam int RES_MAX = 65535;
  localparam int RES_MIN = -65536;

endpackage : mac_pkg

`default_nettype wire

// File: rtl/mac_datapath.sv
// +----------------------------------------------------------------------+
// | mac_datapath : product register, accumulator, valid pipe, saturation |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mac_datapath
  import mac_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [PIX_W-1:0]        pixel,
  input  logic [WGT_W-1:0]        weight,
  output logic signed [RES_W-1:0] sat_result,
  output logic                    sat_overflow
);

  logic                    rd_valid_q;
  logic                    prod_valid_q;
  logic signed [RES_W-1:0] prod_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [RES_W-1:0] pix_ext;
  logic signed [RES_W-1:0] wgt_ext;
  logic signed [RES_W-1:0] product;

  // Pixel is unsigned, weight is two's complement; the product always fits 17 bits.
  assign pix_ext = {{(RES_W-PIX_W){1'b0}}, pixel};
  assign wgt_ext = {{(RES_W-WGT_W){weight[WGT_W-1]}}, weight};
  assign product = pix_ext * wgt_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q   <= 1'b0;
      prod_valid_q <= 1'b0;
      prod_q       <= '0;
      acc_q        <= '0;
    end else if (clear) begin
      rd_valid_q   <= 1'b0;
      prod_valid_q <= 1'b0;
      prod_q       <= '0;
      acc_q        <= '0;
    end else begin
      rd_valid_q   <= in_valid;
      prod_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        prod_q <= product;
      end
      if (prod_valid_q) begin
        acc_q <= acc_q + {{(ACC_W-RES_W){prod_q[RES_W-1]}}, prod_q};
      end
    end
  end

  always_comb begin
    sat_result   = acc_q[RES_W-1:0];
    sat_overflow = 1'b0;
    if (acc_q > RES_MAX) begin
      sat_result   = RES_W'(RES_MAX);
      sat_overflow = 1'b1;
    end else if (acc_q < RES_MIN) begin
      sat_result   = RES_W'(RES_MIN);
      sat_overflow = 1'b1;
    end
  end

endmodule : mac_datapath

`default_nettype wire

// File: rtl/mac_engine.sv
// +----------------------------------------------------------------------+
// | mac_engine : streams pixel/weight SRAMs, returns saturated dot product|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mac_engine
  import mac_pkg::*;
#(
  parameter int NUM_INPUTS = 784,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_calc,
  input  logic [3:0]        output_address,
  output logic [ADDR_W-1:0] pixel_raddr,
  output logic [ADDR_W-1:0] weight_raddr,
  output logic              mem_ren,
  input  logic [15:0]       pixel_rdata,
  input  logic [15:0]       weight_rdata,
  output logic [RES_W-1:0]  result_output,
  output logic [3:0]        result_index,
  output logic              done_calc,
  output logic              overflow,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INPUTS - 1);

  mac_state_t              state_q, state_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic                    drain_q, drain_d;
  logic [3:0]              idx_q, idx_d;
  logic [RES_W-1:0]        res_q, res_d;
  logic [3:0]              res_idx_q, res_idx_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic                    clear;
  logic signed [RES_W-1:0] sat_result;
  logic                    sat_overflow;
  logic                    unused_rdata;

  // Only the low byte of each SRAM word carries data.
  assign unused_rdata = &{1'b0, pixel_rdata[15:PIX_W], weight_rdata[15:WGT_W]};

  mac_datapath u_datapath (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (mem_ren),
    .pixel        (pixel_rdata[PIX_W-1:0]),
    .weight       (weight_rdata[WGT_W-1:0]),
    .sat_result   (sat_result),
    .sat_overflow (sat_overflow)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    idx_d     = idx_q;
    res_d     = res_q;
    res_idx_d = res_idx_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    clear     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_calc) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          idx_d   = output_address;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          clear   = 1'b1;
        end
      end
      S_FETCH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        // Two cycles let the final read and its product reach the accumulator.
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d   = S_IDLE;
        res_d     = sat_result;
        ovf_d     = sat_overflow;
        res_idx_d = idx_q;
        done_d    = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      idx_q     <= '0;
      res_q     <= '0;
      res_idx_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      idx_q     <= idx_d;
      res_q     <= res_d;
      res_idx_q <= res_idx_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pixel_raddr   = cnt_q;
  assign weight_raddr  = cnt_q;
  assign mem_ren       = (state_q == S_FETCH);
  assign busy          = (state_q != S_IDLE);
  assign result_output = res_q;
  assign result_index  = res_idx_q;
  assign done_calc     = done_q;
  assign overflow      = ovf_q;

endmodule : mac_engine

`default_nettype wire

// File: doc/mac_engine.md
# mac_engine

Dot-product engine downstream of `avalon_interface`. On `start_calc` it streams pixel and weight words out of the pixel/weight SRAMs that `avalon_interface` filled. It multiply-accumulates them, then returns a saturated 17-bit signed `result_output` with `done_calc` and `overflow`, tagged with the neuron index taken from `output_address`. It owns the SRAM read ports only; `avalon_interface` owns the write ports (`store_data`, `w_enable_*`).

## Interface
- `NUM_INPUTS`, 784, products accumulated per calculation (1..2047)
- `ADDR_W`, 11, SRAM address width
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start_calc`  in  1  start request from `avalon_interface`
- `output_address`  in  4  neuron index; latched when a start is accepted
- `pixel_raddr`  out  11  pixel SRAM read address
- `weight_raddr`  out  11  weight SRAM read address
- `mem_ren`  out  1  read enable, shared by both SRAMs
- `pixel_rdata`  in  16  pixel word; bits [7:0] are an unsigned pixel; 1-cycle read latency
- `weight_rdata`  in  16  weight word; bits [7:0] are a signed weight; 1-cycle read latency
- `result_output`  out  17  saturated signed dot product
- `result_index`  out  4  latched `output_address` for this result
- `done_calc`  out  1  result valid; level signal
- `overflow`  out  1  accumulator exceeded the 17-bit signed range
- `busy`  out  1  calculation in progress

## Operation
- States: IDLE, FETCH, DRAIN, FINISH.
- IDLE → FETCH when `start_calc`=1. On the accepting edge:
  - latch `output_address`
  - clear the accumulator, `done_calc` and `overflow`
  - set the read counter to 0
- FETCH lasts exactly NUM_INPUTS cycles.
  - `mem_ren`=1.
  - `pixel_raddr`=`weight_raddr`=counter, driven straight from the counter register.
  - Counter increments each cycle.
- FETCH → DRAIN after counter = NUM_INPUTS-1.
- DRAIN lasts 2 cycles and flushes the pipeline. `mem_ren`=0.
- FINISH lasts 1 cycle. At its closing edge:
  - saturate the accumulator and register `result_output`
  - register `result_index` and `overflow`
  - set `done_calc`=1
  - next state is IDLE
- Datapath stages:
  - read data is valid 1 cycle after its address
  - product p = signed({1'b0,pixel[7:0]}) × signed(weight[7:0]), 17-bit signed, registered
  - 32-bit signed accumulator adds p
  - a valid bit travels alongside each stage, so only NUM_INPUTS products are ever added
- Saturation, applied to the 32-bit accumulator value:
  - acc > 65535 → 65535, `overflow`=1
  - acc < -65536 → -65536, `overflow`=1
  - otherwise acc[16:0], `overflow`=0
- `done_calc`, `result_output`, `result_index` and `overflow` hold until the next accepted start or reset.
- Boundary cases:
  - `start_calc` while `busy`: ignored, and the in-progress result is unaffected.
  - `start_calc` in IDLE with `done_calc`=1: accepted; `done_calc` drops on the accepting edge.
  - Reset mid-operation: back to IDLE, and the pipeline valid bits are cleared.
  - NUM_INPUTS=1 is legal.

## Timing
- Reset values:
  - state IDLE
  - `result_output`=0, `result_index`=0
  - `done_calc`=0, `overflow`=0, `busy`=0, `mem_ren`=0
  - `pixel_raddr`=`weight_raddr`=0
  - accumulator and pipeline registers 0
- Let E0 be the edge that samples `start_calc`=1 in IDLE.
  - `busy`=1 from E0 until the FINISH closing edge.
  - Address k is presented during the cycle after E_k, for k = 0..NUM_INPUTS-1.
  - The last product is accumulated at E_(N+2).
  - `done_calc` rises at E_(N+3): 787 edges for N=784.
- Back-to-back: the earliest restart is the edge after `done_calc` rises.

## Structure
- Package `mac_pkg`:
  - state enum `mac_state_t`
  - constants `PIX_W`=8, `WGT_W`=8, `ACC_W`=32, `RES_W`=17
  - `RES_MAX`=65535, `RES_MIN`=-65536
- One sub-module, `mac_datapath`:
  - product register, accumulator, valid pipeline, saturation
  - controlled by `clear`, `in_valid`, `pixel`, `weight`
- The FSM, read counter and output registers stay in `mac_engine`.

## Test plan
- Reset is held while `start_calc`=1, then released → all outputs at their reset values and `busy` stays 0 until a new start.
- All pixels=1, all weights=1, N=784, `output_address`=3 → `result_output`=784, `result_index`=3, `overflow`=0, `done_calc` exactly 787 edges after the start.
- Pixel[i]=i mod 256, weight[i]=-1, N=16 → `result_output`=-120, `overflow`=0.
- All pixels=255, weights=127, N=784 → 65535 with `overflow`=1; weights=-128 instead → -65536 with `overflow`=1.
- `start_calc` pulsed again mid-FETCH → ignored, and the result matches a clean run; a new start after `done_calc` clears `done_calc` on the accepting edge.
- `rst` asserted at counter=400 → IDLE next edge and `done_calc` stays 0; a subsequent all-ones run gives 784.
